// File: rtl/instr_mem_bridge.sv
// Instruction fetch bridge: a 4-entry direct-mapped cache in front of a
// half-width backing memory. A miss is filled with two 16-bit reads (low
// half first), then the assembled instruction is returned.
//
// state | meaning
// IDLE  | waiting for a fetch request; cache lookup happens here
// RD_LO | reading low half-word {A,0} from backing memory
// RD_HI | reading high half-word {A,1}; entry written on ack
// RESP  | o_req_data_valid pulse; back to IDLE next cycle
module instr_mem_bridge #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [RW-1:0]       i_req_addr,
  input  logic                i_req_active,
  output logic [I_SIZE-1:0]   o_req_data,
  output logic                o_req_data_valid,
  output logic [RW:0]         o_mem_addr,
  output logic                o_mem_req,
  input  logic                i_mem_ack,
  input  logic [I_SIZE/2-1:0] i_mem_data,
  input  logic                i_inval
);

  localparam int HW = I_SIZE / 2;
  localparam int TW = RW - 2;

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_t;

  state_t            state;
  state_t            state_nx;
  logic [RW-1:0]     addr_q;
  logic [HW-1:0]     lo_q;
  logic              inval_seen;
  logic [3:0]        valid;
  logic [TW-1:0]     tag_mem  [4];
  logic [I_SIZE-1:0] data_mem [4];

  logic [1:0]        req_idx;
  logic              hit;
  logic              take_req;
  logic              load_hit;
  logic              lo_done;
  logic              fill_done;
  logic              fill_valid;

  assign req_idx    = i_req_addr[1:0];
  assign hit        = valid[req_idx] && (tag_mem[req_idx] == i_req_addr[RW-1:2]);
  // An invalidate seen anywhere during the fill (including the final ack) poisons the entry.
  assign fill_valid = !inval_seen && !i_inval;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and memory-side / response outputs.
  always_comb begin
    state_nx         = state;
    o_mem_req        = 1'b0;
    o_mem_addr       = {addr_q, 1'b0};
    o_req_data_valid = 1'b0;
    take_req         = 1'b0;
    load_hit         = 1'b0;
    lo_done          = 1'b0;
    fill_done        = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_active) begin
          take_req = 1'b1;
          if (hit) begin
            load_hit = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = RD_LO;
          end
        end
      end
      RD_LO: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          lo_done  = 1'b1;
          state_nx = RD_HI;
        end
      end
      RD_HI: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {addr_q, 1'b1};
        if (i_mem_ack) begin
          fill_done = 1'b1;
          state_nx  = RESP;
        end
      end
      RESP: begin
        o_req_data_valid = 1'b1;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Response data register and the fill-poison flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_req_data <= '0;
      inval_seen <= 1'b0;
    end else begin
      if (load_hit)  o_req_data <= data_mem[req_idx];
      if (fill_done) o_req_data <= {i_mem_data, lo_q};
      if (take_req)     inval_seen <= 1'b0;
      else if (i_inval) inval_seen <= 1'b1;
    end
  end

  // Valid bits: global invalidate, then fill write for the latched index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid <= '0;
    end else begin
      if (i_inval)   valid <= '0;
      if (fill_done) valid[addr_q[1:0]] <= fill_valid;
    end
  end

  // Unreset datapath: latched address, low half-word, tag and data arrays.
  always_ff @(posedge i_clk) begin
    if (take_req) addr_q <= i_req_addr;
    if (lo_done)  lo_q   <= i_mem_data;
    if (fill_done && !i_rst) begin
      tag_mem[addr_q[1:0]]  <= addr_q[RW-1:2];
      data_mem[addr_q[1:0]] <= {i_mem_data, lo_q};
    end
  end

endmodule

// File: doc/instr_mem_bridge.md
INSTR_MEM_BRIDGE -- requirements
Module: instr_mem_bridge

Interface
REQ-001 SHALL have parameter RW, default 16, meaning instruction address width in instruction units.
REQ-002 SHALL have parameter I_SIZE, default 32, meaning instruction width; the backing bus is I_SIZE/2 = 16 bits.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req_addr  input  RW  instruction address requested by fetch.
REQ-006 SHALL have port i_req_active  input  1  fetch request present.
REQ-007 SHALL have port o_req_data  output  I_SIZE  returned instruction.
REQ-008 SHALL have port o_req_data_valid  output  1  one-cycle pulse, o_req_data valid.
REQ-009 SHALL have port o_mem_addr  output  RW+1  backing-memory 16-bit word address.
REQ-010 SHALL have port o_mem_req  output  1  backing-memory read request.
REQ-011 SHALL have port i_mem_ack  input  1  backing read completed this cycle.
REQ-012 SHALL have port i_mem_data  input  16  read data, valid when i_mem_ack=1.
REQ-013 SHALL have port i_inval  input  1  invalidate all cache entries.

Function
REQ-014 SHALL hold a 4-entry direct-mapped cache: index = addr[1:0], tag = addr[RW-1:2], one valid bit and one I_SIZE data word per entry.
REQ-015 SHALL implement FSM states IDLE, RD_LO, RD_HI, RESP.
REQ-016 IDLE: if i_req_active=1, latch i_req_addr as A and look up; on hit load o_req_data with entry data and go RESP; on miss go RD_LO; if i_req_active=0 stay IDLE.
REQ-017 RD_LO: o_mem_req=1, o_mem_addr={A,1'b0}; on i_mem_ack capture i_mem_data as instr[15:0] and go RD_HI.
REQ-018 RD_HI: o_mem_req=1, o_mem_addr={A,1'b1}; on i_mem_ack capture i_mem_data as instr[31:16], write entry A[1:0] (tag, data, valid=1), load o_req_data, go RESP.
REQ-019 RESP: o_req_data_valid=1 for exactly this cycle, i_req_addr not sampled; next state IDLE unconditionally.
REQ-020 o_mem_req and o_mem_addr SHALL stay stable until i_mem_ack; ack in the same cycle as request raise is accepted; unlimited wait states allowed.
REQ-021 o_mem_req=0 in IDLE and RESP; i_mem_ack outside RD_LO/RD_HI SHALL be ignored.
REQ-022 Latency: hit, address in cycle t -> valid in t+1; miss with zero-wait ack -> valid in t+3; throughput at most one response per 2 cycles.
REQ-023 o_req_data SHALL hold its value outside RESP until the next load.
REQ-024 i_inval SHALL clear all valid bits at the next edge in any state.
REQ-025 i_inval during RD_LO or RD_HI: the fill completes and the response is delivered, but the entry SHALL NOT be marked valid.
REQ-026 i_inval in the same cycle as the RD_HI ack: invalidation wins; entry written invalid; response still delivered.
REQ-027 i_inval in IDLE with a hitting request: the hit SHALL still be served from pre-invalidation contents.
REQ-028 i_req_active dropping mid-fill SHALL not abort; fill and response complete.
REQ-029 Address wrap: A = 2^RW-1 maps to o_mem_addr 0x1FFFE/0x1FFFF with no overflow into other bits.

Reset
REQ-030 On i_rst: state IDLE, all valid bits 0, o_req_data_valid=0, o_mem_req=0, o_req_data=0; tags and cache data SHALL not require reset.
REQ-031 Reset mid-fill SHALL abandon the fill: o_mem_req=0 from the cycle after reset is sampled, pending ack ignored, no entry written, no response pulse.

Verification
REQ-032 Cold miss: req 0x0000, mem word0=0x1234, word1=0xABCD, zero-wait ack -> o_mem_addr 0x00000 then 0x00001, o_req_data_valid in t+3 with 0xABCD1234.
REQ-033 Re-request 0x0000 -> valid in t+1 with 0xABCD1234, o_mem_req stays 0.
REQ-034 Conflict: req 0x0004 (index 0) misses and replaces; following req 0x0000 misses again with two mem reads.
REQ-035 Wait states: ack delayed 3 cycles per beat -> o_mem_req/o_mem_addr stable throughout, valid in t+9.
REQ-036 i_inval asserted in RD_HI of req 0x0010 -> response delivered, next req 0x0010 misses.
REQ-037 i_rst asserted in RD_LO -> o_mem_req 0 next cycle, no o_req_data_valid, then req 0x0000 misses.
